multdiv_seq: RTL and testbench



---
 rtl/multdiv_seq_pkg.sv | 28 ++
 rtl/multdiv_seq_alu.sv | 49 ++++
 rtl/multdiv_seq.sv | 190 +++++++++++++++++++
 tb/tb_multdiv_seq.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/multdiv_seq_pkg.sv
// Shared constants for the multiply/divide sequencer: ALU opcodes, FSM state
// encoding, operation encoding and the default iteration count.
package multdiv_seq_pkg;

  localparam int ITERS_DEFAULT = 32;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_SLL = 5'd4;
  localparam logic [4:0] ALU_SRA = 5'd5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ABS_A = 3'd1,
    S_ABS_B = 3'd2,
    S_ITER  = 3'd3,
    S_FIX   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

endpackage

// File: rtl/multdiv_seq_alu.sv
// The team's 32-bit ALU: add, subtract, and/or, logical left and arithmetic
// right shift, plus equality / signed less-than / signed overflow flags.
module multdiv_seq_alu
  import multdiv_seq_pkg::*;
(
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic [4:0]  ctrl_ALUopcode,
  input  logic [4:0]  ctrl_shiftamt,
  output logic [31:0] data_result,
  output logic        isNotEqual,
  output logic        isLessThan,
  output logic        overflow
);

  logic [31:0] sum;
  logic [31:0] diff;
  logic        add_ovf;
  logic        sub_ovf;

  assign sum     = data_operandA + data_operandB;
  assign diff    = data_operandA - data_operandB;
  assign add_ovf = (data_operandA[31] == data_operandB[31]) && (sum[31] != data_operandA[31]);
  assign sub_ovf = (data_operandA[31] != data_operandB[31]) && (diff[31] != data_operandA[31]);

  assign isNotEqual = |diff;
  assign isLessThan = diff[31] ^ sub_ovf;

  always_comb begin
    data_result = 32'd0;
    overflow    = 1'b0;
    case (ctrl_ALUopcode)
      ALU_ADD: begin
        data_result = sum;
        overflow    = add_ovf;
      end
      ALU_SUB: begin
        data_result = diff;
        overflow    = sub_ovf;
      end
      ALU_AND: data_result = data_operandA & data_operandB;
      ALU_OR:  data_result = data_operandA | data_operandB;
      ALU_SLL: data_result = data_operandA << ctrl_shiftamt;
      ALU_SRA: data_result = $signed(data_operandA) >>> ctrl_shiftamt;
      default: data_result = 32'd0;
    endcase
  end

endmodule

// File: rtl/multdiv_seq.sv
// Sequential signed 32x32 multiply (shift-add) and divide (restoring), one ALU
// add/subtract per cycle. Sign is stripped up front and reapplied in FIX.
module multdiv_seq
  import multdiv_seq_pkg::*;
#(
  parameter int ITERS = ITERS_DEFAULT
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy,
  output state_e      debug_state
);

  localparam int CW = $clog2(ITERS);

  // Handshake: a start is accepted only in IDLE; busy stays high from the
  // accepting edge through the single data_resultRDY cycle, and the result
  // and exception registers are stable from that cycle until the next DONE.
  state_e      state;
  op_e         op;
  logic        sign;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [CW-1:0] count;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_res;
  logic        alu_ne;
  logic        alu_lt;
  logic        alu_ovf;
  logic        unused_flags;

  logic [31:0] abs_val;
  logic [31:0] rem_sh;
  logic [31:0] q_sh;
  logic        carry;
  logic        borrow;
  logic        mult_exc;

  assign debug_state  = state;
  assign unused_flags = ^{alu_ne, alu_lt, alu_ovf};

  always_comb begin
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    alu_op = ALU_ADD;
    case (state)
      S_ABS_A: begin
        alu_b  = a_reg;
        alu_op = ALU_SUB;
      end
      S_ABS_B: begin
        alu_b  = b_reg;
        alu_op = ALU_SUB;
      end
      S_ITER: begin
        if (op == OP_MULT) begin
          alu_a  = hi;
          alu_b  = a_reg;
          alu_op = ALU_ADD;
        end else begin
          alu_a  = rem_sh;
          alu_b  = b_reg;
          alu_op = ALU_SUB;
        end
      end
      S_FIX: begin
        alu_b  = lo;
        alu_op = ALU_SUB;
      end
      default: ;
    endcase
  end

  multdiv_seq_alu u_alu (
    .data_operandA  (alu_a),
    .data_operandB  (alu_b),
    .ctrl_ALUopcode (alu_op),
    .ctrl_shiftamt  (5'd0),
    .data_result    (alu_res),
    .isNotEqual     (alu_ne),
    .isLessThan     (alu_lt),
    .overflow       (alu_ovf)
  );

  // Carry/borrow out of the 32-bit ALU are rebuilt from operand and result MSBs.
  assign abs_val  = alu_b[31] ? alu_res : alu_b;
  assign rem_sh   = {hi[30:0], lo[31]};
  assign q_sh     = {lo[30:0], 1'b0};
  assign carry    = (alu_a[31] & alu_b[31]) | ((alu_a[31] | alu_b[31]) & ~alu_res[31]);
  assign borrow   = (~alu_a[31] & alu_b[31]) | (~(alu_a[31] ^ alu_b[31]) & alu_res[31]);
  assign mult_exc = (hi != 32'd0) | (lo[31] & ~(sign & (lo == 32'h8000_0000)));

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state          <= S_IDLE;
      op             <= OP_MULT;
      sign           <= 1'b0;
      a_reg          <= 32'd0;
      b_reg          <= 32'd0;
      hi             <= 32'd0;
      lo             <= 32'd0;
      count          <= '0;
      data_result    <= 32'd0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ctrl_MULT || ctrl_DIV) begin
            op    <= ctrl_MULT ? OP_MULT : OP_DIV;
            a_reg <= data_operandA;
            b_reg <= data_operandB;
            sign  <= data_operandA[31] ^ data_operandB[31];
            busy  <= 1'b1;
            state <= S_ABS_A;
          end
        end
        S_ABS_A: begin
          a_reg <= abs_val;
          if (op == OP_DIV && b_reg == 32'd0) begin
            data_result    <= 32'd0;
            data_exception <= 1'b1;
            data_resultRDY <= 1'b1;
            state          <= S_DONE;
          end else begin
            state <= S_ABS_B;
          end
        end
        S_ABS_B: begin
          b_reg <= abs_val;
          hi    <= 32'd0;
          lo    <= (op == OP_MULT) ? abs_val : a_reg;
          count <= '0;
          state <= S_ITER;
        end
        S_ITER: begin
          if (op == OP_MULT) begin
            if (lo[0]) begin
              hi <= {carry, alu_res[31:1]};
              lo <= {alu_res[0], lo[31:1]};
            end else begin
              hi <= {1'b0, hi[31:1]};
              lo <= {hi[0], lo[31:1]};
            end
          end else begin
            if (!borrow) begin
              hi <= alu_res;
              lo <= q_sh | 32'd1;
            end else begin
              hi <= rem_sh;
              lo <= q_sh;
            end
          end
          if (count == CW'(ITERS - 1)) begin
            count <= '0;
            state <= S_FIX;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_FIX: begin
          data_result    <= sign ? alu_res : lo;
          data_exception <= (op == OP_MULT) ? mult_exc : 1'b0;
          data_resultRDY <= 1'b1;
          state          <= S_DONE;
        end
        S_DONE: begin
          data_resultRDY <= 1'b0;
          busy           <= 1'b0;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq: hand-computed products/quotients, latency,
// busy/ready handshake, ignored starts and asynchronous reset mid-operation.
module tb_multdiv_seq;
  import multdiv_seq_pkg::*;

  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
  state_e      debug_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  multdiv_seq dut (
    .clock          (clock),
    .ctrl_reset_n   (ctrl_reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .debug_state    (debug_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one start pulse, count edges until data_resultRDY, check everything.
  // glitch_at > 0 pulses both starts (A=B=5) at that cycle of the operation.
  task automatic run_op(input string tag, input logic mult, input logic div,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic exp_e,
                        input int exp_lat, input int glitch_at);
    int n;
    bit seen;
    bit busy_ok;
    @(negedge clock);
    ctrl_MULT = mult;
    ctrl_DIV = div;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'd0;
    n = 0;
    seen = 1'b0;
    busy_ok = busy;
    while (!seen && n < 100) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (glitch_at > 0 && n == glitch_at) begin
        ctrl_MULT = 1'b1;
        ctrl_DIV = 1'b1;
        data_operandA = 32'd5;
        data_operandB = 32'd5;
      end else if (glitch_at > 0 && n == glitch_at + 1) begin
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'd0;
      end
      if (!busy) busy_ok = 1'b0;
      if (data_resultRDY) seen = 1'b1;
    end
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " busy_held"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " result"}, data_result, exp_r);
    check({tag, " exception"}, {31'd0, data_exception}, {31'd0, exp_e});
    @(negedge clock);
    check({tag, " rdy_pulse_end"}, {31'd0, data_resultRDY}, 32'd0);
    check({tag, " busy_end"}, {31'd0, busy}, 32'd0);
    check({tag, " result_hold"}, data_result, exp_r);
  endtask

  initial begin
    int n;
    bit saw_rdy;
    ctrl_reset_n = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    #2 ctrl_reset_n = 1'b0;
    #1;
    check("reset result", data_result, 32'd0);
    check("reset exception", {31'd0, data_exception}, 32'd0);
    check("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset state", 32'(debug_state), 32'(S_IDLE));
    repeat (2) @(negedge clock);
    ctrl_reset_n = 1'b1;

    run_op("mult 7*-3",        1, 0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 35, 0);
    run_op("mult 2^16*2^16",   1, 0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1, 35, 0);
    run_op("mult min*1",       1, 0, 32'h8000_0000,  32'd1,         32'h8000_0000, 0, 35, 0);
    run_op("mult min*-1",      1, 0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 35, 0);
    run_op("mult -5*-4",       1, 0, 32'hFFFF_FFFB,  32'hFFFF_FFFC, 32'd20,        0, 35, 0);
    run_op("div -7/2",         0, 1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0, 35, 0);
    run_op("div min/-1",       0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0, 35, 0);
    run_op("div 100/7",        0, 1, 32'd100,        32'd7,         32'd14,        0, 35, 0);
    run_op("div -100/7",       0, 1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 0, 35, 0);
    run_op("div 5/0",          0, 1, 32'd5,          32'd0,         32'd0,         1, 1,  0);
    run_op("both 6,3",         1, 1, 32'd6,          32'd3,         32'd18,        0, 35, 0);
    run_op("ignored start",    1, 0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 35, 10);

    // Reset at ITER iteration 15 (edge E17 after start) must abort silently.
    @(negedge clock);
    ctrl_MULT = 1'b1;
    data_operandA = 32'd1000;
    data_operandB = 32'd1000;
    @(posedge clock);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    n = 0;
    saw_rdy = 1'b0;
    while (n < 17) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (data_resultRDY) saw_rdy = 1'b1;
    end
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    check("pre-reset state", 32'(debug_state), 32'(S_ITER));
    #2 ctrl_reset_n = 1'b0;
    #1;
    check("midreset result", data_result, 32'd0);
    check("midreset exception", {31'd0, data_exception}, 32'd0);
    check("midreset rdy", {31'd0, data_resultRDY}, 32'd0);
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset state", 32'(debug_state), 32'(S_IDLE));
    repeat (3) begin
      @(negedge clock);
      if (data_resultRDY) saw_rdy = 1'b1;
    end
    ctrl_reset_n = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY || busy) saw_rdy = 1'b1;
    end
    check("midreset no_rdy", {31'd0, saw_rdy}, 32'd0);

    run_op("mult 2*3 after reset", 1, 0, 32'd2, 32'd3, 32'd6, 0, 35, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
